mili_seq_ctrl: RTL and testbench



---
 rtl/mili_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_mili_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mili_seq_ctrl.sv
// Serial run controller for a Mealy sequence-detector FSM: clears it, feeds a word LSB first
// at one step per DIV clocks, and captures y per bit. Optional hit counter: MILI_SEQ_HITCNT_EN.
//   state | meaning
//   IDLE  | waiting for start
//   CLEAR | fsm_rst_n low for one cycle
//   STEP  | one bit per DIV clocks, strobe when prescaler hits 0
//   DONE  | done pulse, dout valid
module mili_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             fsm_rst_n,
  output logic             fsm_en,
  output logic             fsm_a,
  input  logic             fsm_y
`ifdef MILI_SEQ_HITCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] hit_cnt
`endif
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] RELOAD = PW'(DIV - 1);
  localparam logic [BW-1:0] LAST   = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx, dout_nx;
  logic [BW-1:0]    bitcnt, bitcnt_nx;
  logic [PW-1:0]    presc, presc_nx;
  logic             strobe;
`ifdef MILI_SEQ_HITCNT_EN
  logic [BW-1:0]    hits_nx;
`endif

  assign strobe = (state == STEP) && (presc == '0);
  assign fsm_a  = (state == STEP) & sr[0];

  always_comb begin
    state_nx  = state;
    sr_nx     = sr;
    dout_nx   = dout;
    bitcnt_nx = bitcnt;
    presc_nx  = presc;
`ifdef MILI_SEQ_HITCNT_EN
    hits_nx   = hit_cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          sr_nx     = din;
          dout_nx   = '0;
          bitcnt_nx = '0;
`ifdef MILI_SEQ_HITCNT_EN
          hits_nx   = '0;
`endif
          state_nx  = CLEAR;
        end
      end
      CLEAR: begin
        presc_nx = RELOAD;
        state_nx = STEP;
      end
      STEP: begin
        if (strobe) begin
          // y is sampled with the pre-update FSM state and the current a
          for (int i = 0; i < WIDTH; i++)
            if (BW'(i) == bitcnt) dout_nx[i] = fsm_y;
          sr_nx     = sr >> 1;
          bitcnt_nx = bitcnt + 1'b1;
          presc_nx  = RELOAD;
`ifdef MILI_SEQ_HITCNT_EN
          hits_nx   = hit_cnt + BW'(fsm_y);
`endif
          if (bitcnt == LAST) state_nx = DONE;
        end else begin
          presc_nx = presc - 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      dout      <= '0;
      bitcnt    <= '0;
      presc     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fsm_rst_n <= 1'b1;
      fsm_en    <= 1'b0;
`ifdef MILI_SEQ_HITCNT_EN
      hit_cnt   <= '0;
`endif
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      dout      <= dout_nx;
      bitcnt    <= bitcnt_nx;
      presc     <= presc_nx;
      busy      <= (state_nx == CLEAR) || (state_nx == STEP);
      done      <= (state_nx == DONE);
      fsm_rst_n <= (state_nx != CLEAR);
      fsm_en    <= (state_nx == STEP) && (presc_nx == '0);
`ifdef MILI_SEQ_HITCNT_EN
      hit_cnt   <= hits_nx;
`endif
    end
  end

endmodule

// File: tb/tb_mili_seq_ctrl.sv
// Bench for mili_seq_ctrl: two instances (DIV=1 and DIV=4, WIDTH=8), each driving a small
// Mealy FSM model; a run-level timing model is compared with the outputs every cycle.
module tb_mili_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [2];
  logic [7:0] din   [2];
  logic       busy  [2];
  logic       done  [2];
  logic [7:0] dout  [2];
  logic       frst  [2];
  logic       fen   [2];
  logic       fa    [2];
  logic       fy    [2];
`ifdef MILI_SEQ_HITCNT_EN
  logic [3:0] hit   [2];
`endif

  int divs [2] = '{1, 4};
  int npass = 0;
  int ntot  = 0;
  logic armed = 1'b0;

  always #5 clk = ~clk;

  mili_seq_ctrl #(.WIDTH(8), .DIV(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .din(din[0]),
    .busy(busy[0]), .done(done[0]), .dout(dout[0]),
    .fsm_rst_n(frst[0]), .fsm_en(fen[0]), .fsm_a(fa[0]), .fsm_y(fy[0])
`ifdef MILI_SEQ_HITCNT_EN
    , .hit_cnt(hit[0])
`endif
  );

  mili_seq_ctrl #(.WIDTH(8), .DIV(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .din(din[1]),
    .busy(busy[1]), .done(done[1]), .dout(dout[1]),
    .fsm_rst_n(frst[1]), .fsm_en(fen[1]), .fsm_a(fa[1]), .fsm_y(fy[1])
`ifdef MILI_SEQ_HITCNT_EN
    , .hit_cnt(hit[1])
`endif
  );

  // Controlled FSM: a=0 walks S0->S1->S2->S3->S0; a=1 holds S1 (y=1), else returns to S0 (y=0)
  function automatic logic ymap(int s, logic a);
    return a && (s == 1);
  endfunction

  function automatic int nextmap(int s, logic a);
    if (!a) return (s + 1) % 4;
    return (s == 1) ? 1 : 0;
  endfunction

  function automatic logic [7:0] exp_dout(logic [7:0] d);
    int s = 0;
    logic [7:0] r = '0;
    for (int k = 0; k < 8; k++) begin
      r[k] = ymap(s, d[k]);
      s = nextmap(s, d[k]);
    end
    return r;
  endfunction

  int fst [2];
  assign fy[0] = ymap(fst[0], fa[0]);
  assign fy[1] = ymap(fst[1], fa[1]);

  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 2; i++) begin
      if (!rst_n)       fst[i] <= 0;
      else if (!frst[i]) fst[i] <= 0;
      else if (fen[i])   fst[i] <= nextmap(fst[i], fa[i]);
    end

  // Run model: t = edges since the accepting edge E0
  logic       act  [2];
  int         t    [2];
  logic [7:0] rdin [2];
  logic [7:0] held [2];

  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        act[i]  <= 1'b0;
        t[i]    <= 0;
        rdin[i] <= '0;
        held[i] <= '0;
      end else if (act[i]) begin
        if (t[i] == 8 * divs[i] + 1) act[i] <= 1'b0;
        t[i] <= t[i] + 1;
      end else if (start[i]) begin
        act[i]  <= 1'b1;
        t[i]    <= 0;
        rdin[i] <= din[i];
        held[i] <= exp_dout(din[i]);
      end
    end

  task automatic check(input string nm, input int inst, input logic [31:0] got, input logic [31:0] expv);
    ntot++;
    if (got === expv) npass++;
    else $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, inst, $time, got, expv);
  endtask

  always @(negedge clk) begin
    int   wd, tt;
    logic eb, ed, er, ee, ea;
    if (armed)
      for (int i = 0; i < 2; i++) begin
        wd = 8 * divs[i];
        tt = t[i];
        eb = 1'b0; ed = 1'b0; er = 1'b1; ee = 1'b0; ea = 1'b0;
        if (act[i]) begin
          eb = (tt <= wd);
          er = (tt != 0);
          ee = (tt >= divs[i]) && (tt <= wd) && (tt % divs[i] == 0);
          ea = (tt >= 1 && tt <= wd) ? rdin[i][(tt - 1) / divs[i]] : 1'b0;
          ed = (tt == wd + 1);
        end
        check("busy", i, 32'(busy[i]), 32'(eb));
        check("done", i, 32'(done[i]), 32'(ed));
        check("fsm_rst_n", i, 32'(frst[i]), 32'(er));
        check("fsm_en", i, 32'(fen[i]), 32'(ee));
        check("fsm_a", i, 32'(fa[i]), 32'(ea));
        if (!act[i] || ed) begin
          check("dout", i, 32'(dout[i]), 32'(held[i]));
`ifdef MILI_SEQ_HITCNT_EN
          check("hit_cnt", i, 32'(hit[i]), 32'($countones(held[i])));
`endif
        end
      end
  end

  task automatic run(input int i, input logic [7:0] d, input logic [7:0] lit, input int lat, input int hits);
    int n;
    @(negedge clk);
    start[i] = 1'b1;
    din[i]   = d;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    start[i] = 1'b0;
    while (!done[i] && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", i, 32'(n), 32'(lat));
    check("dout_lit", i, 32'(dout[i]), 32'(lit));
`ifdef MILI_SEQ_HITCNT_EN
    check("hit_lit", i, 32'(hit[i]), 32'(hits));
`else
    if (hits < 0) $display("bad hit expectation");
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, rl, ns, nd;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      din[i]   = '0;
    end
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", i, 32'(busy[i]), 0);
      check("rst_done", i, 32'(done[i]), 0);
      check("rst_dout", i, 32'(dout[i]), 0);
      check("rst_fsm_rst_n", i, 32'(frst[i]), 1);
      check("rst_fsm_en", i, 32'(fen[i]), 0);
      check("rst_fsm_a", i, 32'(fa[i]), 0);
    end
    armed = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run(0, 8'hFE, 8'hFE, 9, 7);
    check("fsm_state_fe", 0, 32'(fst[0]), 1);
    run(0, 8'h00, 8'h00, 9, 0);
    check("fsm_state_00", 0, 32'(fst[0]), 0);
    run(1, 8'hAA, 8'h22, 33, 2);
    run(1, 8'h00, 8'h00, 33, 0);

    // start held high: back-to-back runs
    @(negedge clk);
    start[0] = 1'b1;
    din[0]   = 8'hFE;
    n = 0;
    while (!done[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("first_done", 0, 32'(done[0]), 1);
    n = 0;
    rl = 0;
    do begin
      @(negedge clk);
      n++;
      if (!frst[0]) rl++;
    end while (!done[0] && n < 100);
    start[0] = 1'b0;
    check("restart_period", 0, 32'(n), 11);
    check("clear_cycles", 0, 32'(rl), 1);
    check("dout_repeat", 0, 32'(dout[0]), 32'h00FE);
    repeat (3) @(negedge clk);

    // reset after the third strobe of an AA run
    start[1] = 1'b1;
    din[1]   = 8'hAA;
    @(negedge clk);
    start[1] = 1'b0;
    ns = 0;
    n  = 0;
    while (ns < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (fen[1]) ns++;
    end
    check("strobes_pre_rst", 1, 32'(ns), 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 1, 32'(busy[1]), 0);
    check("midrst_fsm_en", 1, 32'(fen[1]), 0);
    check("midrst_dout", 1, 32'(dout[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[1]) nd++;
    end
    check("no_done_after_rst", 1, 32'(nd), 0);
    run(1, 8'hFE, 8'hFE, 33, 7);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d/%0d passed so far", npass, ntot);
    $fatal(1);
  end

endmodule
